// File: rtl/dsram_axi_bridge_pkg.sv
// Shared types and constants for the data-SRAM to AXI4 bridge and its decoders.
package dsram_axi_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_AR   = 3'd1,
    ST_RD_R    = 3'd2,
    ST_WR_AW_W = 3'd3,
    ST_WR_B    = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  localparam logic [2:0] SIZE_B = 3'd0;
  localparam logic [2:0] SIZE_H = 3'd1;
  localparam logic [2:0] SIZE_W = 3'd2;

endpackage

// File: rtl/dsram_axi_bridge_if.sv
// Single-beat AXI4 channel bundle between the data-side bridge (master) and the bus.
interface dsram_axi_bridge_if;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;

  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arsize, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready,
    output awid, awaddr, awsize, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bresp, bvalid, output bready
  );

  modport slave (
    input  arid, araddr, arsize, arvalid, output arready,
    output rdata, rresp, rvalid, input rready,
    input  awid, awaddr, awsize, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bresp, bvalid, input bready
  );

endinterface

// File: rtl/dsram_wstrb_size.sv
// Byte-strobe to AXI transfer-size decoder: full word, aligned halfword, single byte.
module dsram_wstrb_size
  import dsram_axi_bridge_pkg::*;
(
  input  logic [3:0] i_wstrb,
  output logic [2:0] o_size
);

  always_comb begin
    // NOTE: default assignment before the case so every path drives o_size and no latch is inferred.
    o_size = SIZE_W;
    case (i_wstrb)
      4'b0011, 4'b1100:                   o_size = SIZE_H;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: o_size = SIZE_B;
      default:                            o_size = SIZE_W;
    endcase
  end

endmodule

// File: rtl/dsram_axi_bridge.sv
// Core data-SRAM port to single-beat AXI4 bridge, one access outstanding, stalls the core meanwhile.
// Define DSRAM_BRIDGE_ERR_EN to enable sticky error capture on non-OKAY rresp/bresp.
module dsram_axi_bridge
  import dsram_axi_bridge_pkg::*;
#(
  parameter logic [3:0] AXI_ID  = 4'd1,
  parameter logic [2:0] RD_SIZE = 3'd2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_sram_en,
  input  logic [3:0]        data_sram_wen,
  input  logic [31:0]       data_sram_addr,
  input  logic [31:0]       data_sram_wdata,
  output logic [31:0]       data_sram_rdata,
  output logic              stallreq,
  dsram_axi_bridge_if.master axi,
  output logic              err_valid,
  output logic [31:0]       err_addr
);

  state_t      r_state;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [31:0] r_rdata;
  logic        r_arvalid, r_rready, r_awvalid, r_wvalid, r_bready;
  logic        r_aw_done, r_w_done;

  logic [2:0]  w_awsize;
  logic        w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs;
  logic        w_aw_fin, w_w_fin;

  dsram_wstrb_size u_wstrb_size (
    .i_wstrb (r_wstrb),
    .o_size  (w_awsize)
  );

  assign w_ar_hs  = r_arvalid & axi.arready;
  assign w_r_hs   = r_rready  & axi.rvalid;
  assign w_aw_hs  = r_awvalid & axi.awready;
  assign w_w_hs   = r_wvalid  & axi.wready;
  assign w_b_hs   = r_bready  & axi.bvalid;
  assign w_aw_fin = r_aw_done | w_aw_hs;
  assign w_w_fin  = r_w_done  | w_w_hs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_rdata   <= '0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      case (r_state)
        ST_IDLE: begin
          if (data_sram_en) begin
            r_addr  <= data_sram_addr;
            r_wdata <= data_sram_wdata;
            r_wstrb <= data_sram_wen;
            if (data_sram_wen == 4'b0000) begin
              r_arvalid <= 1'b1;
              r_state   <= ST_RD_AR;
            end else begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= ST_WR_AW_W;
            end
          end
        end
        ST_RD_AR: begin
          if (w_ar_hs) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_RD_R;
          end
        end
        ST_RD_R: begin
          if (w_r_hs) begin
            r_rready <= 1'b0;
            r_rdata  <= axi.rdata;
            r_state  <= ST_DONE;
          end
        end
        ST_WR_AW_W: begin
          // AW and W complete independently; the done flags remember an earlier handshake.
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_fin && w_w_fin) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_bready  <= 1'b1;
            r_state   <= ST_WR_B;
          end
        end
        ST_WR_B: begin
          if (w_b_hs) begin
            r_bready <= 1'b0;
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // In IDLE the stall follows the request combinationally; DONE releases the pipeline for one cycle.
  assign stallreq = rst & ((r_state == ST_IDLE) ? data_sram_en : (r_state != ST_DONE));
  assign data_sram_rdata = r_rdata;

  assign axi.arid    = AXI_ID;
  assign axi.araddr  = r_addr;
  assign axi.arsize  = RD_SIZE;
  assign axi.arvalid = r_arvalid;
  assign axi.rready  = r_rready;
  assign axi.awid    = AXI_ID;
  assign axi.awaddr  = r_addr;
  assign axi.awsize  = w_awsize;
  assign axi.awvalid = r_awvalid;
  assign axi.wdata   = r_wdata;
  assign axi.wstrb   = r_wstrb;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = r_wvalid;
  assign axi.bready  = r_bready;

`ifdef DSRAM_BRIDGE_ERR_EN
  logic        r_err_valid;
  logic [31:0] r_err_addr;
  logic        w_resp_err;

  assign w_resp_err = (w_r_hs && (axi.rresp != AXI_RESP_OKAY)) ||
                      (w_b_hs && (axi.bresp != AXI_RESP_OKAY));

  // Sticky until reset; the first failing access address is kept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_valid <= 1'b0;
      r_err_addr  <= '0;
    end else if (w_resp_err && !r_err_valid) begin
      r_err_valid <= 1'b1;
      r_err_addr  <= r_addr;
    end
  end

  assign err_valid = r_err_valid;
  assign err_addr  = r_err_addr;
`else
  assign err_valid = 1'b0;
  assign err_addr  = '0;
`endif

endmodule

// File: doc/dsram_axi_bridge.md
Name: dsram_axi_bridge

Overview:
- Sits directly downstream of the CPU core's data-SRAM port and converts the core's one-cycle SRAM-style data access (en/wen/addr/wdata/rdata) into single-beat AXI4 read/write transactions.
- Raises a stall request to the core's CTRL path while a transaction is outstanding.
- Returns read data registered and stable for the MEM stage.
- Allows one outstanding access at a time.

Parameters:
- AXI_ID, 4'd1, constant ARID/AWID driven on every transaction.
- RD_SIZE, 3'd2, ARSIZE for all reads (word; the core selects bytes itself).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- data_sram_en  input  1  core access request, held stable while stallreq=1
- data_sram_wen  input  4  byte write enables; 0 = read
- data_sram_addr  input  32  byte address
- data_sram_wdata  input  32  store data, byte-lane aligned
- data_sram_rdata  output  32  registered read data
- stallreq  output  1  to CTRL: freeze pipeline
- arid/araddr/arsize/arvalid  output  4/32/3/1  AXI read address
- arready  input  1
- rdata/rresp/rvalid  input  32/2/1;  rready  output  1
- awid/awaddr/awsize/awvalid  output  4/32/3/1;  awready  input  1
- wdata/wstrb/wlast/wvalid  output  32/4/1/1;  wready  input  1
- bresp/bvalid  input  2/1;  bready  output  1
- err_valid  output  1  (feature only)
- err_addr  output  32  (feature only)

Behaviour:
- Reset (rst=0, async):
  - FSM=IDLE.
  - All AXI valid/ready outputs=0.
  - data_sram_rdata=0, stallreq=0.
  - Latched addr/wdata/wstrb=0.
  - Reset mid-transaction abandons it; the AXI slave is reset by the same net.
- FSM states: IDLE, RD_AR, RD_R, WR_AW_W, WR_B, DONE.
- IDLE:
  - data_sram_en=1 latches addr, wdata, wen.
  - wen==0 -> RD_AR; else -> WR_AW_W.
  - stallreq = data_sram_en (combinational) in the accept cycle.
- RD_AR: arvalid=1, araddr=latched addr, arsize=RD_SIZE. On arvalid&arready -> RD_R.
- RD_R:
  - rready=1.
  - On rvalid: data_sram_rdata<=rdata, -> DONE.
  - rresp is ignored unless the feature is on.
- WR_AW_W:
  - awvalid and wvalid asserted together; wlast=1, wstrb=latched wen.
  - Each channel drops independently after its handshake (aw_done, w_done flags).
  - When both are done (same or different cycles) -> WR_B.
- awsize from wen:
  - 4'b1111 -> 2
  - 4'b0011 or 4'b1100 -> 1
  - one-hot -> 0
  - other patterns -> 2
- awaddr = latched addr with low bits unchanged.
- WR_B: bready=1. On bvalid -> DONE.
- DONE:
  - Lasts exactly one cycle; stallreq=0 so the pipeline advances.
  - The request still presented by the core in this cycle is NOT re-accepted.
  - Always -> IDLE.
- stallreq=1 in every state except IDLE (where it equals data_sram_en) and DONE.
- Latency with zero-wait slave (ready high, response next cycle):
  - Read: accept, AR, R, DONE = stall for 3 cycles.
  - Write: accept, AW/W, B, DONE = stall for 3 cycles.
- data_sram_rdata holds its value until the next completed read; writes do not alter it.
- A valid, once asserted, is never dropped before its handshake (AXI rule); latched fields are stable throughout.
- Back-to-back accesses: the next request is accepted in the IDLE cycle directly after DONE.

Optional Feature:
- Macro: DSRAM_BRIDGE_ERR_EN.
- Defined:
  - rresp or bresp != 2'b00 sets sticky err_valid=1 and captures err_addr = the access address (first error wins).
  - Cleared only by reset.
- Undefined: err_valid=0 and err_addr=0 constantly; responses are not checked.

Decomposition:
- Shared defines header holds:
  - FSM state encodings
  - AXI_RESP_OKAY
  - AXI size constants (SIZE_B/H/W)
- One natural sub-module, dsram_wstrb_size: the combinational wen->awsize decoder, reused later by the instruction-side bridge.

Test Plan:
- Read, zero-wait: en=1, wen=0, addr=0x1000_0040, slave returns 0xDEAD_BEEF.
  - araddr=0x1000_0040, arsize=2.
  - stallreq high for 3 cycles.
  - data_sram_rdata=0xDEAD_BEEF from the DONE cycle on.
- Byte store: wen=4'b0100, addr=0x1000_0002, wdata=0x00AB_0000.
  - awsize=0, wstrb=4'b0100, wdata=0x00AB_0000.
  - Single B handshake, then DONE.
- Split write handshakes: awready delayed 3 cycles, wready immediate.
  - wvalid drops after 1 cycle; awvalid held until accepted; WR_B entered only after both.
- Back-pressure: arready low 5 cycles, rvalid delayed 4 cycles.
  - arvalid/araddr stable throughout.
  - stallreq continuous.
  - Exactly one DONE cycle, no duplicate transaction.
- Async reset asserted in RD_R mid-transaction: all valids and stallreq go to 0 immediately; FSM returns to IDLE.
- With DSRAM_BRIDGE_ERR_EN: bresp=2'b10 at addr 0xBFAF_0000 gives err_valid=1 and err_addr=0xBFAF_0000; a later OKAY leaves both unchanged.
